recip_arbiter: RTL and testbench
================================

# recip_arbiter

Round-robin arbiter sharing one pipelined integer reciprocal unit (XRecip) between REQUESTERS independent clients. Grants at most one request per clock, feeds the winning operand to the shared unit, and carries a valid/ID/zero-flag tag down a delay line matched to the unit's fixed latency. Results come back on one broadcast port tagged with the originating requester. Sits between the float datapath clients (divide, normalize stages) and the single reciprocal instance.

## Interface
- NUMBER_WIDTH, 24, operand width; forwarded to XRecip
- ITERATIONS, 2, Newton iterations; forwarded to XRecip
- REQUESTERS, 4, number of clients, 2..16
- RECIP_LATENCY, 7 + 3*ITERATIONS, XRecip input-to-output latency in clocks; must match the instance
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  REQUESTERS  per-client operand valid
- req_ready  out  REQUESTERS  per-client grant, one-hot or zero
- req_value  in  REQUESTERS*NUMBER_WIDTH  operands, client i at bits [i*NUMBER_WIDTH +: NUMBER_WIDTH]
- res_valid  out  1  result valid, one-cycle pulse per accepted request
- res_id  out  max(1,$clog2(REQUESTERS))  index of client owning the result
- res_value  out  2*NUMBER_WIDTH  reciprocal, same format as XRecip out
- res_div_zero  out  1  operand was zero; res_value forced all ones
- busy  out  1  any request in flight

## Operation
- Handshake: transfer on req_valid[i] & req_ready[i]. req_ready is combinational from req_valid and the priority pointer; no backpressure on the result port (clients must always accept).
- Arbitration: round-robin. Pointer last_grant resets to REQUESTERS-1, so client 0 has top priority after reset. Search order last_grant+1, +2, … wrapping modulo REQUESTERS; first valid client is granted. last_grant updates only on a transfer.
- At most one req_ready bit high; all zero when no req_valid. req_ready is 0 while reset asserted.
- Granted operand drives XRecip.in combinationally; with no grant, XRecip.in is driven 0 and the tag is invalid.
- Tag delay line: RECIP_LATENCY stages of {valid, id, zero}; stage 0 loads on every clock; stage RECIP_LATENCY-1 drives res_valid/res_id/res_div_zero.
- Zero operand: accepted normally; res_div_zero=1 and res_value = all ones in its result cycle.
- res_value/res_id hold don't-care when res_valid=0; bench checks them only with res_valid.
- busy = OR of all tag valid bits.
- Reset (any time, including mid-flight): all tag valid bits, res_valid, res_div_zero, busy cleared to 0, res_id 0, last_grant to REQUESTERS-1; in-flight XRecip data discarded (XRecip itself is unreset). No result appears for requests accepted before reset.

## Timing
- Request transferred in cycle k → res_valid high in exactly cycle k+RECIP_LATENCY, for one cycle.
- Throughput: one transfer per clock total; back-to-back results in acceptance order, no reordering.
- Arbitration is zero-latency: a request may be granted in the same cycle it is raised.
- Under continuous requests from all clients, each client is granted exactly once every REQUESTERS cycles.
- Reset values: req_ready 0, res_valid 0, res_id 0, res_value 0, res_div_zero 0, busy 0.

## Structure
- Package recip_arb_pkg: ID width function (max(1,$clog2(n))), tag struct {valid, id, zero}, default latency function 7+3*ITERATIONS.
- Sub-module rr_arbiter: REQUESTERS-wide combinational round-robin grant plus registered pointer; reused by other shared float units.
- Top: rr_arbiter, operand mux, zero detect, tag shift register, XRecip instance, result zero-override.

## Test plan
- Single request client 2, value 4 (NUMBER_WIDTH 24) → res_valid exactly 13 cycles later, res_id 2, res_value 0x400000 (±1 LSB), res_div_zero 0.
- All four clients valid continuously for 8 cycles from reset → grants 0,1,2,3,0,1,2,3; results in same order, one per cycle, values matching each operand's reciprocal.
- Clients 1 and 3 only, client 1 dropping after one grant → grants 1,3,3,3; pointer wrap verified via client 0 raised later getting priority after 3.
- Client 0 value 0 → res_div_zero 1, res_value 0xFFFFFFFFFFFF, res_id 0, busy high for the 13 cycles in flight.
- Issue 5 requests, assert reset 6 cycles later for 2 cycles → no res_valid ever for those requests, busy 0 immediately, next request after reset granted to client 0 first.
- Random valid patterns, 10k cycles → every transfer yields exactly one result at +RECIP_LATENCY with correct id; no starvation (max wait < REQUESTERS cycles).

Source files
------------

// File: rtl/recip_arb_pkg.sv
// Shared types and helpers for the reciprocal-unit arbiter and its round-robin core.
package recip_arb_pkg;

    // Widest client index the tag line can carry (up to 16 clients).
    localparam int ID_MAX_W = 4;

    // Client index width: max(1, clog2(n)).
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Input-to-output latency of the reciprocal unit for a given iteration count.
    function automatic int recip_latency(input int iterations);
        return 7 + 3 * iterations;
    endfunction

    // Tag carried alongside an operand through the reciprocal pipeline.
    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic                zero;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, id: {ID_MAX_W{1'b0}}, zero: 1'b0};

endpackage

// File: rtl/XRecip.sv
// Pipelined integer reciprocal: out = 2^NUMBER_WIDTH / in, all ones for in == 0.
// Functional model with the fixed latency of the iterative unit; datapath unreset.
module XRecip
    import recip_arb_pkg::*;
#(
    parameter int NUMBER_WIDTH = 24,
    parameter int ITERATIONS   = 2
) (
    input  logic                      clk,
    input  logic [NUMBER_WIDTH-1:0]   in,
    output logic [2*NUMBER_WIDTH-1:0] out
);

    localparam int              LAT = recip_latency(ITERATIONS);
    localparam int              OW  = 2 * NUMBER_WIDTH;
    localparam logic [OW-1:0]   ONE = {{(OW-1){1'b0}}, 1'b1} << NUMBER_WIDTH;

    logic [OW-1:0] quot_s;
    logic [OW-1:0] pipe_r [LAT];

    // Reciprocal of the current operand; zero saturates to all ones.
    always_comb begin
        if (in == {NUMBER_WIDTH{1'b0}}) begin
            quot_s = {OW{1'b1}};
        end else begin
            quot_s = ONE / {{NUMBER_WIDTH{1'b0}}, in};
        end
    end

    // Latency-matching pipeline.
    always_ff @(posedge clk) begin
        pipe_r[0] <= quot_s;
        for (int i = 1; i < LAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
        end
    end

    assign out = pipe_r[LAT-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: combinational search starting after the last winner,
// with a registered pointer that advances only when something is granted.
module rr_arbiter
    import recip_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    output logic [N-1:0]           grant,
    output logic [id_width(N)-1:0] grant_idx
);

    localparam int           IW        = id_width(N);
    localparam logic [IW:0]  N_W       = (IW+1)'(N);
    localparam logic [IW-1:0] LAST_INIT = IW'(N - 1);

    logic [IW-1:0] last_grant_r;
    logic [IW:0]   sum_s;
    logic [IW-1:0] cand_s;
    logic          found_s;

    // Search last_grant+1 .. last_grant+N (mod N); first requesting client wins.
    always_comb begin
        grant     = {N{1'b0}};
        grant_idx = {IW{1'b0}};
        found_s   = 1'b0;
        sum_s     = {(IW+1){1'b0}};
        cand_s    = {IW{1'b0}};
        if (!reset) begin
            for (int off = 1; off <= N; off++) begin
                sum_s = {1'b0, last_grant_r} + (IW+1)'(off);
                if (sum_s >= N_W) begin
                    sum_s = sum_s - N_W;
                end else begin
                    sum_s = sum_s;
                end
                cand_s = sum_s[IW-1:0];
                if (!found_s && req[cand_s]) begin
                    found_s       = 1'b1;
                    grant[cand_s] = 1'b1;
                    grant_idx     = cand_s;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end

    // Pointer register: remembers the most recent winner; reset favours client 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= LAST_INIT;
        end else if (found_s) begin
            last_grant_r <= grant_idx;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/recip_arbiter.sv
// Shares one pipelined reciprocal unit among several clients: round-robin grant,
// operand mux, and a tag line matched to the unit latency that routes results back.
module recip_arbiter
    import recip_arb_pkg::*;
#(
    parameter int NUMBER_WIDTH  = 24,
    parameter int ITERATIONS    = 2,
    parameter int REQUESTERS    = 4,
    parameter int RECIP_LATENCY = recip_latency(ITERATIONS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [REQUESTERS-1:0]              req_valid,
    output logic [REQUESTERS-1:0]              req_ready,
    input  logic [REQUESTERS*NUMBER_WIDTH-1:0] req_value,
    output logic                               res_valid,
    output logic [id_width(REQUESTERS)-1:0]    res_id,
    output logic [2*NUMBER_WIDTH-1:0]          res_value,
    output logic                               res_div_zero,
    output logic                               busy
);

    localparam int IW = id_width(REQUESTERS);
    localparam int OW = 2 * NUMBER_WIDTH;

    logic [REQUESTERS-1:0]   grant_s;
    logic [IW-1:0]           grant_idx_s;
    logic [ID_MAX_W-1:0]     id_ext_s;
    logic [NUMBER_WIDTH-1:0] operand_s;
    logic [OW-1:0]           recip_out_s;
    tag_t                    tag_in_s;
    tag_t                    tag_r [RECIP_LATENCY];
    tag_t                    tag_out_s;
    logic                    unused_id_s;

    rr_arbiter #(.N(REQUESTERS)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign req_ready = grant_s;

    // Route the winning operand to the shared unit; idle cycles feed zero.
    always_comb begin
        operand_s = {NUMBER_WIDTH{1'b0}};
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_s[i]) begin
                operand_s = req_value[i*NUMBER_WIDTH +: NUMBER_WIDTH];
            end else begin
                operand_s = operand_s;
            end
        end
    end

    // Build the tag for this cycle: valid on grant, zero flag from the operand.
    always_comb begin
        id_ext_s         = {ID_MAX_W{1'b0}};
        id_ext_s[IW-1:0] = grant_idx_s;
        tag_in_s.valid   = |grant_s;
        tag_in_s.id      = id_ext_s;
        tag_in_s.zero    = (|grant_s) && (operand_s == {NUMBER_WIDTH{1'b0}});
    end

    // Tag delay line; reset drops everything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RECIP_LATENCY; i++) begin
                tag_r[i] <= TAG_IDLE;
            end
        end else begin
            tag_r[0] <= tag_in_s;
            for (int i = 1; i < RECIP_LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    XRecip #(.NUMBER_WIDTH(NUMBER_WIDTH), .ITERATIONS(ITERATIONS)) u_recip (
        .clk (clk),
        .in  (operand_s),
        .out (recip_out_s)
    );

    assign tag_out_s    = tag_r[RECIP_LATENCY-1];
    assign res_valid    = tag_out_s.valid;
    assign res_id       = tag_out_s.id[IW-1:0];
    assign res_div_zero = tag_out_s.valid & tag_out_s.zero;
    assign unused_id_s  = ^tag_out_s.id;

    // Result data: zero when idle (unit output is unreset), all ones for a zero operand.
    always_comb begin
        if (!tag_out_s.valid) begin
            res_value = {OW{1'b0}};
        end else if (tag_out_s.zero) begin
            res_value = {OW{1'b1}};
        end else begin
            res_value = recip_out_s;
        end
    end

    // Busy while any tag is in flight.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < RECIP_LATENCY; i++) begin
            busy = busy | tag_r[i].valid;
        end
    end

endmodule

// File: tb/tb_recip_arbiter.sv
// Directed and random bench for recip_arbiter with a result scoreboard.
module tb_recip_arbiter;

    localparam int NW   = 24;
    localparam int NREQ = 4;
    localparam int LAT  = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [95:0]     req_value;
    logic            res_valid;
    logic [1:0]      res_id;
    logic [47:0]     res_value;
    logic            res_div_zero;
    logic            busy;

    typedef struct {
        int          id;
        logic [47:0] val;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          res_count = 0;
    logic [3:0]  granted_last = 4'b0;
    int          wait_cnt[4];
    exp_t        mon_e;
    logic [23:0] mon_v;

    always #5 clk = ~clk;

    recip_arbiter #(
        .NUMBER_WIDTH(NW), .ITERATIONS(2), .REQUESTERS(NREQ), .RECIP_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_value(req_value), .res_valid(res_valid), .res_id(res_id),
        .res_value(res_value), .res_div_zero(res_div_zero), .busy(busy)
    );

    function automatic logic [47:0] ref_recip(input logic [23:0] v);
        if (v == 24'h0) return 48'hFFFF_FFFF_FFFF;
        return 48'h00_0001_000000 / {24'h0, v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        longint d;
        total++;
        d = longint'({16'h0, obs}) - longint'({16'h0, exp});
        assert (!$isunknown(obs) && d >= -1 && d <= 1) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (+-1)", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records transfers into the scoreboard, checks every result.
    always @(negedge clk) begin
        granted_last = 4'b0;
        if (reset) begin
            sb.delete();
            for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
            chk("rst_res_valid", res_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_ready", req_ready, 4'b0);
        end else begin
            chk("ready_onehot", $onehot0(req_ready), 1'b1);
            chk("ready_any", |req_ready, |req_valid);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_v      = req_value[i*NW +: NW];
                    mon_e.id   = i;
                    mon_e.val  = ref_recip(mon_v);
                    mon_e.zero = (mon_v == 24'h0);
                    mon_e.cyc  = cyc;
                    sb.push_back(mon_e);
                    grant_log.push_back(i);
                    granted_last[i] = 1'b1;
                    wait_cnt[i] = 0;
                end else if (req_valid[i]) begin
                    wait_cnt[i]++;
                    chk("starve", wait_cnt[i] < NREQ, 1'b1);
                end else begin
                    wait_cnt[i] = 0;
                end
            end
            if (res_valid) begin
                res_count++;
                chk("sb_nonempty", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("latency", cyc - mon_e.cyc, LAT);
                    chk("res_id", res_id, mon_e.id);
                    chk("res_dz", res_div_zero, mon_e.zero);
                    if (mon_e.zero) chk("res_value_zero", res_value, 48'hFFFF_FFFF_FFFF);
                    else            chk_near("res_value", res_value, mon_e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
        chk("drain_empty", sb.size(), 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int snap;
        int exp3 [5];

        // Reset state with all clients requesting.
        reset     = 1'b1;
        req_valid = 4'hF;
        req_value = {24'd3, 24'd5, 24'd7, 24'd9};
        repeat (3) @(negedge clk);
        chk("rst_res_id", res_id, 2'd0);
        chk("rst_res_value", res_value, 48'h0);
        chk("rst_res_dz", res_div_zero, 1'b0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 4'h0;
        tick();

        // Single request from client 2 with operand 4.
        req_value[2*NW +: NW] = 24'd4;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        for (n = 1; n < 30; n++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        chk("s1_latency", n, LAT);
        chk("s1_id", res_id, 2'd2);
        chk_near("s1_value", res_value, 48'h400000);
        chk("s1_dz", res_div_zero, 1'b0);
        drain();

        // All clients continuously for 8 cycles from reset.
        pulse_reset(2);
        grant_log.delete();
        req_valid = 4'hF;
        repeat (8) begin
            for (int i = 0; i < NREQ; i++) req_value[i*NW +: NW] = 24'($urandom_range(1, 24'hFFFFFF));
            tick();
        end
        req_valid = 4'h0;
        chk("s2_count", grant_log.size(), 8);
        for (int j = 0; j < 8 && j < grant_log.size(); j++) chk("s2_grant", grant_log[j], j % NREQ);
        drain();

        // Clients 1 and 3, client 1 drops, then client 0 joins after 3.
        pulse_reset(1);
        grant_log.delete();
        req_valid = 4'b1010;
        tick();
        req_valid = 4'b1000;
        repeat (3) tick();
        req_valid = 4'b1001;
        tick();
        req_valid = 4'b0000;
        exp3 = '{1, 3, 3, 3, 0};
        chk("s3_count", grant_log.size(), 5);
        for (int j = 0; j < 5 && j < grant_log.size(); j++) chk("s3_grant", grant_log[j], exp3[j]);
        drain();

        // Zero operand on client 0; busy held for the whole flight.
        req_value[0 +: NW] = 24'd0;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        for (int j = 0; j < LAT; j++) begin
            @(negedge clk);
            chk("s4_busy", busy, 1'b1);
            chk("s4_res_valid", res_valid, j == LAT - 1);
            if (j == LAT - 1) begin
                chk("s4_dz", res_div_zero, 1'b1);
                chk("s4_value", res_value, 48'hFFFF_FFFF_FFFF);
                chk("s4_id", res_id, 2'd0);
            end
        end
        @(negedge clk);
        chk("s4_busy_end", busy, 1'b0);
        tick();

        // Reset mid-flight discards results; pointer returns to favour client 0.
        snap = res_count;
        req_valid = 4'hF;
        repeat (5) tick();
        req_valid = 4'h0;
        repeat (6) tick();
        reset = 1'b1;
        @(negedge clk);
        chk("s5_busy", busy, 1'b0);
        chk("s5_res_valid", res_valid, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) tick();
        chk("s5_no_result", res_count - snap, 0);
        grant_log.delete();
        req_valid = 4'hF;
        tick();
        req_valid = 4'h0;
        chk("s5_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        drain();

        // Random traffic; pending requests are held until granted.
        for (int c = 0; c < 10000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !granted_last[i])) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_value[i*NW +: NW] = ($urandom_range(0, 15) == 0) ? 24'h0 : 24'($urandom);
                end
            end
        end
        tick();
        req_valid = 4'h0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
